fp_pack_round: RTL and testbench
================================

Name: fp_pack_round

Overview:
- Inverse of the FP unpacking helpers: takes an unpacked result (sign, wide biased exponent, extended significand with carry/guard/round/sticky) from the adder datapath.
- Normalizes, rounds to nearest-even and packs it into a 32-bit IEEE-754 single-precision word.
- Multi-cycle, one shift per cycle; valid/ready on both sides. Sits at the tail of the FP add/sub pipeline, before writeback.

Parameters:
- EXP_W, 10, width of the signed input exponent (biased by 127; wider than 8 to carry overflow/underflow)
- MANT_W, 28, input significand width; fixed layout below, only 28 supported

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input word valid
- in_ready  out  1  block can accept (high only in IDLE)
- in_sign  in  1  result sign
- in_exp  in  EXP_W  signed biased exponent
- in_mant  in  MANT_W  [27]=carry, [26]=hidden, [25:3]=fraction, [2]=G, [1]=R, [0]=S; value = mant/2^26 * 2^(exp-127)
- out_valid  out  1  packed result valid
- out_ready  in  1  consumer accepts
- out_word  out  32  {sign, exp[7:0], frac[22:0]}
- out_ovf  out  1  result overflowed to infinity
- out_inexact  out  1  any of G/R/S nonzero before rounding

Behaviour:
- Reset (async, rst_n=0): state=IDLE, in_ready=1, out_valid=0, out_word=0, out_ovf=0, out_inexact=0, internal regs cleared. Reset mid-operation discards the in-flight result; no output is produced.
- States: IDLE -> NORM -> ROUND -> DONE -> IDLE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready, register sign/exp/mant and go to NORM.
- NORM: one step per cycle, priority order:
  - mant==0: zero; force exp=0, go ROUND.
  - mant[27]=1: mant>>=1, S|=shifted-out bit, exp+=1.
  - exp<=0: denormalize. If exp<-25, mant={27'b0, |mant}, exp=1. Else mant>>=1 with sticky, exp+=1.
  - mant[26]=0 and exp>1: mant<<=1, exp-=1.
  - Otherwise go ROUND. The deciding cycle performs no shift.
- ROUND (1 cycle):
  - lsb=mant[3]; up = G & (R|S|lsb); inexact = G|R|S.
  - mant[27:3] += up. If the carry reaches bit 27, shift right 1 and exp+=1.
  - Result with exp>=255 -> out_word={sign,8'hFF,23'h0}, out_ovf=1.
  - mant[26]=0 with exp==1 -> encoded exponent 0 (denormal/zero).
  - Otherwise exp[7:0] and mant[25:3].
- DONE:
  - out_valid=1; outputs stable while out_valid&!out_ready.
  - On out_ready go IDLE; out_valid drops next cycle. Flags hold until the next result is loaded.
- Latency (accept edge to out_valid): 3 + number of shift steps. Already-normalized input = 3 cycles.
- No pipelining: a new input is not accepted until DONE completes. Simultaneous out_ready and in_valid in DONE: the input is accepted only after returning to IDLE (in_ready low in DONE).
- Sign is preserved for zero and infinity. NaN is never generated.

Optional Feature:
- Macro FP_PACK_FAST_NORM_EN.
- Defined: NORM completes in exactly one cycle using a leading-zero count and barrel shift (same result, sticky and denormal rules). Latency is fixed at 3.
- Undefined: the iterative one-bit-per-cycle behaviour above.
- out_word, out_ovf and out_inexact are identical in both builds.

Test Plan:
- 1.0: sign=0, exp=127, mant=28'h4000000 -> out_word=32'h3F800000, inexact=0, out_valid 3 cycles after accept.
- Carry: exp=127, mant=28'h8000000 -> 32'h40000000 (2.0), latency 4 (3 with FAST_NORM).
- Left normalize: exp=130, mant=28'h0800000 -> 32'h3F800000, latency 6 (3 with FAST_NORM).
- Tie-to-even:
  - mant=28'h4000004 (G=1, lsb=0) -> 32'h3F800000, inexact=1.
  - mant=28'h400000C (lsb=1) -> 32'h3F800002.
- Overflow: exp=254, mant=28'h8000000 -> 32'h7F800000, out_ovf=1. Zero: sign=1, mant=0 -> 32'h80000000.
- Backpressure/reset: hold out_ready=0 for 5 cycles -> out_word stable, in_ready=0. Assert rst_n=0 during NORM -> out_valid=0, in_ready=1 immediately.

Source files
------------

// File: rtl/fp_pack_round.sv
// Normalize, round-to-nearest-even and pack an unpacked adder result into IEEE-754 single.
// Define FP_PACK_FAST_NORM_EN for single-cycle LZC/barrel normalization; default is one shift per cycle.
module fp_pack_round #(
    parameter int EXP_W  = 10,
    parameter int MANT_W = 28
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_sign,
    input  logic [EXP_W-1:0]  in_exp,
    input  logic [MANT_W-1:0] in_mant,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_word,
    output logic              out_ovf,
    output logic              out_inexact
);
    // Two guard bits of headroom so carry/round increments never wrap the signed exponent
    localparam int XW = EXP_W + 2;
    localparam logic signed [XW-1:0] E_ZERO = '0;
    localparam logic signed [XW-1:0] E_ONE  = XW'(1);
    localparam logic signed [XW-1:0] E_M25  = XW'(-25);
    localparam logic signed [XW-1:0] E_255  = XW'(255);

    typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;

    state_t                 state_q, state_d;
    logic                   sign_q, sign_d;
    logic signed [XW-1:0]   exp_q, exp_d;
    logic [MANT_W-1:0]      mant_q, mant_d;
    logic [31:0]            word_q, word_d;
    logic                   ovf_q, ovf_d;
    logic                   inexact_q, inexact_d;

    logic [MANT_W-1:0]      norm_mant;
    logic signed [XW-1:0]   norm_exp;
    logic                   norm_done;

`ifdef FP_PACK_FAST_NORM_EN
    logic signed [XW-1:0]   lz;
    logic signed [XW-1:0]   lim;
    logic [4:0]             sh;
    logic                   found;
    logic                   stick;

    // Carry shift, then denormalize or left-normalize in one pass; matches the iterative result
    always_comb begin
        norm_mant = mant_q;
        norm_exp  = exp_q;
        norm_done = 1'b1;
        lz        = '0;
        lim       = '0;
        sh        = '0;
        found     = 1'b0;
        stick     = 1'b0;
        if (mant_q == '0) begin
            norm_exp = E_ZERO;
        end else begin
            if (norm_mant[27]) begin
                norm_mant = {1'b0, norm_mant[27:2], norm_mant[1] | norm_mant[0]};
                norm_exp  = norm_exp + E_ONE;
            end
            if (norm_exp <= E_ZERO) begin
                if (norm_exp < E_M25) begin
                    norm_mant = {27'b0, 1'b1};
                end else begin
                    lim = E_ONE - norm_exp;
                    sh  = lim[4:0];
                    for (int unsigned i = 0; i < 28; i++) begin
                        if (i < 32'(sh)) stick = stick | norm_mant[i];
                    end
                    norm_mant    = norm_mant >> sh;
                    norm_mant[0] = norm_mant[0] | stick;
                end
                norm_exp = E_ONE;
            end else if (!norm_mant[26]) begin
                for (int unsigned i = 0; i < 27; i++) begin
                    if (!found) begin
                        if (norm_mant[26-i]) found = 1'b1;
                        else lz = lz + E_ONE;
                    end
                end
                lim = norm_exp - E_ONE;
                sh  = (lim < lz) ? lim[4:0] : lz[4:0];
                norm_mant = norm_mant << sh;
                norm_exp  = norm_exp - XW'(sh);
            end
        end
    end
`else
    always_comb begin
        norm_mant = mant_q;
        norm_exp  = exp_q;
        norm_done = 1'b0;
        if (mant_q == '0) begin
            norm_exp  = E_ZERO;
            norm_done = 1'b1;
        end else if (mant_q[27]) begin
            norm_mant = {1'b0, mant_q[27:2], mant_q[1] | mant_q[0]};
            norm_exp  = exp_q + E_ONE;
        end else if (exp_q <= E_ZERO) begin
            if (exp_q < E_M25) begin
                norm_mant = {27'b0, 1'b1};
                norm_exp  = E_ONE;
            end else begin
                norm_mant = {1'b0, mant_q[27:2], mant_q[1] | mant_q[0]};
                norm_exp  = exp_q + E_ONE;
            end
        end else if (!mant_q[26] && exp_q > E_ONE) begin
            norm_mant = {mant_q[26:0], 1'b0};
            norm_exp  = exp_q - E_ONE;
        end else begin
            norm_done = 1'b1;
        end
    end
`endif

    logic                   rnd_up;
    logic [24:0]            rnd_sum;
    logic [24:0]            rnd_sig;
    logic signed [XW-1:0]   rnd_exp;

    always_comb begin
        rnd_up  = mant_q[2] & (mant_q[1] | mant_q[0] | mant_q[3]);
        rnd_sum = mant_q[27:3] + {24'b0, rnd_up};
        rnd_sig = rnd_sum;
        rnd_exp = exp_q;
        if (rnd_sum[24]) begin
            rnd_sig = {1'b0, rnd_sum[24:1]};
            rnd_exp = exp_q + E_ONE;
        end
    end

    always_comb begin
        state_d   = state_q;
        sign_d    = sign_q;
        exp_d     = exp_q;
        mant_d    = mant_q;
        word_d    = word_q;
        ovf_d     = ovf_q;
        inexact_d = inexact_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sign_d  = in_sign;
                    exp_d   = {{2{in_exp[EXP_W-1]}}, in_exp};
                    mant_d  = in_mant;
                    state_d = NORM;
                end
            end
            NORM: begin
                mant_d = norm_mant;
                exp_d  = norm_exp;
                if (norm_done) state_d = ROUND;
            end
            ROUND: begin
                inexact_d = |mant_q[2:0];
                if (rnd_exp >= E_255) begin
                    word_d = {sign_q, 8'hFF, 23'h0};
                    ovf_d  = 1'b1;
                end else begin
                    // Hidden bit clear means exponent 1 or 0: both encode as a zero/denormal field
                    word_d = {sign_q, rnd_sig[23] ? rnd_exp[7:0] : 8'h00, rnd_sig[22:0]};
                    ovf_d  = 1'b0;
                end
                state_d = DONE;
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            sign_q    <= 1'b0;
            exp_q     <= '0;
            mant_q    <= '0;
            word_q    <= '0;
            ovf_q     <= 1'b0;
            inexact_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sign_q    <= sign_d;
            exp_q     <= exp_d;
            mant_q    <= mant_d;
            word_q    <= word_d;
            ovf_q     <= ovf_d;
            inexact_q <= inexact_d;
        end
    end

    assign in_ready    = (state_q == IDLE);
    assign out_valid   = (state_q == DONE);
    assign out_word    = word_q;
    assign out_ovf     = ovf_q;
    assign out_inexact = inexact_q;

endmodule

// File: tb/tb_fp_pack_round.sv
// Directed scoreboard bench for fp_pack_round: packing, rounding, latency, backpressure, reset.
module tb_fp_pack_round;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [9:0]  in_exp;
    logic [27:0] in_mant;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_word;
    logic        out_ovf;
    logic        out_inexact;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] word;
        logic        ovf;
        logic        inx;
        int          lat;
    } exp_t;
    exp_t sb[$];

`ifdef FP_PACK_FAST_NORM_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    fp_pack_round #(.EXP_W(10), .MANT_W(28)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_sign(in_sign), .in_exp(in_exp), .in_mant(in_mant),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_word(out_word), .out_ovf(out_ovf), .out_inexact(out_inexact)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic int lat_of(input int shifts);
        return FAST ? 3 : 3 + shifts;
    endfunction

    // Latency counts the accept edge as cycle 1, through the edge that raises out_valid
    task automatic send(input string tag, input logic s, input logic [9:0] e, input logic [27:0] m,
                        input logic [31:0] w, input logic ovf, input logic inx,
                        input int shifts, input int hold);
        exp_t x;
        exp_t got;
        int   cyc;
        x.word = w; x.ovf = ovf; x.inx = inx; x.lat = lat_of(shifts);
        sb.push_back(x);
        @(negedge clk);
        in_valid = 1'b1; in_sign = s; in_exp = e; in_mant = m;
        chk({tag, ".in_ready"}, {31'b0, in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        cyc = 1;
        while (out_valid !== 1'b1 && cyc < 60) begin
            @(posedge clk); #1;
            cyc++;
        end
        got = sb.pop_front();
        chk({tag, ".latency"}, 32'(cyc), 32'(got.lat));
        chk({tag, ".word"}, out_word, got.word);
        chk({tag, ".ovf"}, {31'b0, out_ovf}, {31'b0, got.ovf});
        chk({tag, ".inexact"}, {31'b0, out_inexact}, {31'b0, got.inx});
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk({tag, ".hold_valid"}, {31'b0, out_valid}, 32'd1);
            chk({tag, ".hold_in_ready"}, {31'b0, in_ready}, 32'd0);
            chk({tag, ".hold_word"}, out_word, got.word);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, ".valid_drop"}, {31'b0, out_valid}, 32'd0);
        chk({tag, ".inexact_held"}, {31'b0, out_inexact}, {31'b0, got.inx});
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_sign = 1'b0; in_exp = '0; in_mant = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.in_ready", {31'b0, in_ready}, 32'd1);
        chk("rst.out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst.out_word", out_word, 32'h0);
        chk("rst.out_ovf", {31'b0, out_ovf}, 32'd0);
        chk("rst.out_inexact", {31'b0, out_inexact}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        send("one",        1'b0, 10'd127, 28'h4000000, 32'h3F800000, 1'b0, 1'b0, 0, 0);
        send("carry",      1'b0, 10'd127, 28'h8000000, 32'h40000000, 1'b0, 1'b0, 1, 0);
        send("left3",      1'b0, 10'd130, 28'h0800000, 32'h3F800000, 1'b0, 1'b0, 3, 0);
        send("tie_even",   1'b0, 10'd127, 28'h4000004, 32'h3F800000, 1'b0, 1'b1, 0, 0);
        send("tie_odd",    1'b0, 10'd127, 28'h400000C, 32'h3F800002, 1'b0, 1'b1, 0, 0);
        send("ovf_carry",  1'b0, 10'd254, 28'h8000000, 32'h7F800000, 1'b1, 1'b0, 1, 0);
        send("neg_zero",   1'b1, 10'd127, 28'h0000000, 32'h80000000, 1'b0, 1'b0, 0, 0);
        send("denorm_e0",  1'b0, 10'd0,   28'h4000000, 32'h00400000, 1'b0, 1'b0, 1, 0);
        send("underflow",  1'b0, 10'h3E2, 28'h4000000, 32'h00000000, 1'b0, 1'b1, 1, 0);
        send("rnd_carry",  1'b1, 10'd127, 28'h7FFFFFC, 32'hC0000000, 1'b0, 1'b1, 0, 0);
        send("ovf_exp",    1'b1, 10'd300, 28'h4000000, 32'hFF800000, 1'b1, 1'b0, 0, 0);
        send("left_limit", 1'b0, 10'd3,   28'h0800000, 32'h00400000, 1'b0, 1'b0, 2, 0);
        send("backpress",  1'b0, 10'd128, 28'h6000000, 32'h40400000, 1'b0, 1'b0, 0, 5);

        // Reset while the block is in NORM discards the result
        @(negedge clk);
        in_valid = 1'b1; in_sign = 1'b0; in_exp = 10'd130; in_mant = 28'h0800000;
        @(posedge clk); #1;
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("midrst.out_valid", {31'b0, out_valid}, 32'd0);
        chk("midrst.in_ready", {31'b0, in_ready}, 32'd1);
        chk("midrst.out_word", out_word, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            chk("midrst.no_output", {31'b0, out_valid}, 32'd0);
        end
        send("after_rst",  1'b0, 10'd127, 28'h4000000, 32'h3F800000, 1'b0, 1'b0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
